// File: rtl/list_builder_pkg.sv
// Shared linked-list definitions: pointer type, null terminator, FSM states
// and the completed-head record kept in the head FIFO.
package list_builder_pkg;

   localparam int N     = 16;
   localparam int Width = $clog2(N);

   typedef logic [Width-1:0] Pointer;

   localparam Pointer NullPtr = Pointer'(0);
   // Longest list that can be built: every legal pointer 1..N-1 used once.
   localparam Pointer MaxLen  = Pointer'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,  // waiting for the first element of a list
      LINK = 2'd1,  // partial list open, prev holds its tail
      TERM = 2'd2   // write the null terminator and publish the head
   } state_e;

   typedef struct packed {
      Pointer ptr;
      Pointer len;
   } head_t;

endpackage

// File: rtl/list_builder_head_fifo.sv
// Small synchronous FIFO holding completed list heads, oldest first.
// A push that coincides with a pop is accepted even when full.
module head_fifo #(
   parameter int Depth = 2,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] pop_data,
   output logic          full,
   output logic          empty
);

   localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CW = $clog2(Depth + 1);

   logic [DW-1:0] mem [Depth];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(Depth));
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   // Present zero while empty so the head outputs read as their reset values.
   assign pop_data = empty ? '0 : mem[rd_ptr];

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(Depth - 1)) ? '0 : p + AW'(1);
   endfunction

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage; contents are don't-care while their slot is unoccupied.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/list_builder.sv
// Writer end of the linked-list path: links a stream of element pointers
// into singly linked lists in next-pointer memory and publishes each
// finished list's (head, length) in completion order.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, is meant to hold with stable payload
// until that edge; ready may change freely and is never a function of
// valid. This applies to in_vld/in_rdy and head_vld/head_rdy.
module list_builder
   import list_builder_pkg::*;
#(
   parameter int HeadDepth = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [Width-1:0] in_ptr,
   input  logic             in_last,
   input  logic             in_vld,
   output logic             in_rdy,
   output logic             wr_en,
   output logic [Width-1:0] wr_addr,
   output logic [Width-1:0] wr_data,
   output logic [Width-1:0] head_ptr,
   output logic [Width-1:0] head_len,
   output logic             head_vld,
   input  logic             head_rdy,
   output logic             err,
   output state_e           fsm_state
);

   state_e state;
   state_e state_nx;
   Pointer head_q;
   Pointer prev_q;
   Pointer len_q;

   logic   fifo_full;
   logic   fifo_empty;
   logic   accept;
   logic   is_null;
   logic   wr_en_d;
   Pointer wr_addr_d;
   Pointer wr_data_d;
   logic   err_d;
   logic   push;
   logic   load_first;
   logic   extend;
   head_t  push_entry;
   head_t  pop_entry;

   assign in_rdy    = (state != TERM) & ~fifo_full;
   assign accept    = in_vld & in_rdy;
   assign is_null   = (in_ptr == NullPtr);
   assign fsm_state = state;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next state: null elements never move the FSM; a full list is closed
   // by whatever element arrives next.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept && !is_null && !in_last) state_nx = LINK;
         LINK: if (accept && !is_null && (in_last || len_q == MaxLen)) state_nx = TERM;
         TERM: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs: the memory write, error and FIFO push for this cycle.
   always_comb begin
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr;
      wr_data_d  = wr_data;
      err_d      = accept & is_null;
      push       = 1'b0;
      push_entry = '{ptr: head_q, len: len_q};
      load_first = 1'b0;
      extend     = 1'b0;
      case (state)
         IDLE: begin
            if (accept && !is_null) begin
               load_first = 1'b1;
               if (in_last) begin
                  wr_en_d    = 1'b1;
                  wr_addr_d  = in_ptr;
                  wr_data_d  = NullPtr;
                  push       = 1'b1;
                  push_entry = '{ptr: in_ptr, len: Pointer'(1)};
               end
            end
         end
         LINK: begin
            if (accept && !is_null) begin
               if (len_q == MaxLen) begin
                  err_d = 1'b1;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = prev_q;
                  wr_data_d = in_ptr;
                  extend    = 1'b1;
               end
            end
         end
         TERM: begin
            wr_en_d   = 1'b1;
            wr_addr_d = prev_q;
            wr_data_d = NullPtr;
            push      = 1'b1;
         end
         default: ;
      endcase
   end

   // Partial-list tracking: head, current tail and running length.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q <= NullPtr;
         prev_q <= NullPtr;
         len_q  <= '0;
      end else if (load_first) begin
         head_q <= in_ptr;
         prev_q <= in_ptr;
         len_q  <= Pointer'(1);
      end else if (extend) begin
         prev_q <= in_ptr;
         len_q  <= len_q + Pointer'(1);
      end
   end

   // Registered write port and error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en   <= 1'b0;
         wr_addr <= NullPtr;
         wr_data <= NullPtr;
         err     <= 1'b0;
      end else begin
         wr_en   <= wr_en_d;
         wr_addr <= wr_addr_d;
         wr_data <= wr_data_d;
         err     <= err_d;
      end
   end

   head_fifo #(
      .Depth (HeadDepth),
      .DW    ($bits(head_t))
   ) u_head_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (head_rdy),
      .pop_data  (pop_entry),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_vld = ~fifo_empty;
   assign head_ptr = pop_entry.ptr;
   assign head_len = pop_entry.len;

endmodule
